// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state
// encodings (also visible on the debug `state` port) and default widths.
package seq_tx_pkg;

    localparam int PAT_W_DEF = 8;   // maximum pattern length in bits
    localparam int LEN_W_DEF = 4;   // width of the length field
    localparam int RPT_W_DEF = 4;   // width of the repeat count

    // One-hot-ish encoding is fixed so the debug port matches the detector's
    // flip-flop view of the stream.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_SHIFT = 3'b001,
        ST_GAP   = 3'b010,
        ST_DONE  = 3'b100
    } state_t;

endpackage

// File: rtl/seq_tx_shifter.sv
// Loadable left-shift window with a bit counter. A load left-aligns the
// low `load_len` bits of the pattern so the first bit to send sits in the
// MSB. `msb_next` is the bit the window will present after the coming edge,
// which lets the top register x_out without an extra cycle of latency.
module seq_tx_shifter
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_pat,
    input  logic [LEN_W-1:0] load_len,
    output logic             msb_next,
    output logic             last
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

    logic [PAT_W-1:0] window_reg;
    logic [PAT_W-1:0] window_next;
    logic [PAT_W-1:0] shifted;
    logic [LEN_W-1:0] cnt_reg;
    logic [LEN_W-1:0] cnt_next;

    // Window moved one place toward the MSB, zero filled at the bottom.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shifted[gi] = 1'b0;
            end else begin : g_upper
                assign shifted[gi] = window_reg[gi-1];
            end
        end
    endgenerate

    // Load takes priority over shift; the counter holds at zero.
    always_comb begin
        window_next = window_reg;
        cnt_next    = cnt_reg;
        if (load) begin
            window_next = load_pat << (MAX_LEN - load_len);
            cnt_next    = load_len;
        end else if (shift) begin
            window_next = shifted;
            cnt_next    = (cnt_reg != '0) ? cnt_reg - LEN_W'(1) : cnt_reg;
        end
    end

    // Window and bit-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            window_reg <= window_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign msb_next = window_next[PAT_W-1];
    assign last     = (cnt_reg == LEN_W'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter feeding the sequence detector's X input.
// Sends a latched pattern MSB-first, repeating it rpt+1 times with a
// one-cycle gap between passes, then pulses done for one cycle.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int RPT_W = RPT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [RPT_W-1:0] rpt,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

    state_t           state_reg;
    state_t           state_next;
    logic [PAT_W-1:0] pat_reg;
    logic [LEN_W-1:0] len_reg;
    logic [RPT_W-1:0] pass_reg;
    logic [RPT_W-1:0] pass_next;
    logic [LEN_W-1:0] eff_len;

    logic             load;
    logic             shift;
    logic [PAT_W-1:0] load_pat;
    logic [LEN_W-1:0] load_len;
    logic             msb_next;
    logic             last;

    logic x_out_reg, x_out_next;
    logic x_valid_reg, x_valid_next;
    logic busy_reg, busy_next;
    logic done_reg, done_next;

    // Requests longer than the window are sent as a full-width pattern.
    assign eff_len = (len > MAX_LEN) ? MAX_LEN : len;

    seq_tx_shifter #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .load_pat (load_pat),
        .load_len (load_len),
        .msb_next (msb_next),
        .last     (last)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus shifter/pass-counter control; abort outranks everything.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        shift      = 1'b0;
        load_pat   = pat_reg;
        load_len   = len_reg;
        pass_next  = pass_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    load_pat   = pattern;
                    load_len   = eff_len;
                    pass_next  = rpt;
                    state_next = (eff_len == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    shift = 1'b1;
                    if (last) begin
                        state_next = (pass_reg != '0) ? ST_GAP : ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    // Reload here so the first bit of the next pass is
                    // already on x_out when SHIFT is re-entered.
                    load       = 1'b1;
                    pass_next  = pass_reg - RPT_W'(1);
                    state_next = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pattern/length latch and pass counter; inputs are frozen after start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_reg  <= '0;
            len_reg  <= '0;
            pass_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                pat_reg <= pattern;
                len_reg <= eff_len;
            end
            pass_reg <= pass_next;
        end
    end

    // Output values for the cycle that follows the coming edge.
    always_comb begin
        x_valid_next = (state_next == ST_SHIFT);
        x_out_next   = x_valid_next & msb_next;
        busy_next    = (state_next == ST_SHIFT) || (state_next == ST_GAP);
        done_next    = (state_next == ST_DONE);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_out_reg   <= 1'b0;
            x_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            x_out_reg   <= x_out_next;
            x_valid_reg <= x_valid_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign x_out   = x_out_reg;
    assign x_valid = x_valid_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign state   = state_reg;

endmodule
